// File: rtl/sprite_line_engine.sv
// rtl/sprite_line_engine.sv - scanline sprite compositor with ping-pong line buffers
// Renders line v+1 into the back buffer during blanking of line v, then streams it read-then-clear.
module sprite_line_engine #(
  parameter int N_SPR      = 20,
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int ID_W       = 4,
  parameter int PIX_W      = 8,
  parameter int ROM_LAT    = 1,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525,
  // clk cycles between hcount==H_ACTIVE and the following hcount==0
  parameter int BLANK_CLKS = 768
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic [24*N_SPR-1:0]                     gl_array_i,
  input  logic [9:0]                              hcount_i,
  input  logic [9:0]                              vcount_i,
  output logic [ID_W+$clog2(SPR_H*SPR_W)-1:0]     rom_addr_o,
  input  logic [PIX_W-1:0]                        rom_data_i,
  output logic [PIX_W-1:0]                        pix_out_o,
  output logic                                    overrun_o
);

  localparam int CW  = $clog2(SPR_W);
  localparam int RW  = $clog2(SPR_H);
  localparam int AW  = $clog2(H_ACTIVE);
  localparam int SW  = (N_SPR > 1) ? $clog2(N_SPR) : 1;
  localparam int RAW = ID_W + RW + CW;

  if (N_SPR * (SPR_W + ROM_LAT + 2) + 2 >= BLANK_CLKS) begin : g_budget_check
    $error("sprite_line_engine: worst-case render does not fit in blanking");
  end
  if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_lat_check
    $error("sprite_line_engine: ROM_LAT must be 1..4");
  end

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_FETCH, S_DRAIN, S_NEXT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [9:0]        t_q, t_d, t_next;
  logic [ID_W-1:0]   id_q, id_d;
  logic [9:0]        x_q, x_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [2:0]        dcnt_q, dcnt_d;
  logic              issue, swap_now, abort;
  logic [23:0]       desc_arr [N_SPR];
  logic [23:0]       desc;
  logic [10:0]       diff;
  logic [RAW-1:0]    rom_addr_q;
  logic [ROM_LAT:0]  p_vld_q;
  logic [ROM_LAT:0][10:0] p_pos_q;
  logic              wr_en, disp_en, disp_sel, wr_sel;
  logic [AW-1:0]     wr_addr, haddr, clr_q;
  logic              sel_q, clr_busy_q, overrun_q;
  logic [PIX_W-1:0]  pix_out_q;
  logic [PIX_W-1:0]  rd_data [2];

  for (genvar g = 0; g < N_SPR; g++) begin : g_desc
    assign desc_arr[g] = gl_array_i[g*24 +: 24];
  end

  assign desc   = desc_arr[s_q];
  assign diff   = {1'b0, t_q} - {1'b0, desc[9:0]};
  assign t_next = (vcount_i == 10'(V_TOTAL - 1)) ? 10'd0 : vcount_i + 10'd1;

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    t_d      = t_q;
    id_d     = id_q;
    x_d      = x_q;
    row_d    = row_q;
    col_d    = col_q;
    dcnt_d   = dcnt_q;
    issue    = 1'b0;
    swap_now = 1'b0;
    abort    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hcount_i == 10'(H_ACTIVE) && t_next < 10'(V_ACTIVE)) begin
          state_d = S_SCAN;
          s_d     = SW'(N_SPR - 1);
          t_d     = t_next;
        end
      end
      S_SCAN: begin
        id_d    = desc[20 +: ID_W];
        x_d     = desc[19:10];
        row_d   = diff[RW-1:0];
        col_d   = '0;
        // a sprite below the target line wraps the difference to a large value and misses
        state_d = (desc[20 +: ID_W] != '0 && diff < 11'(SPR_H)) ? S_FETCH : S_NEXT;
      end
      S_FETCH: begin
        issue = 1'b1;
        col_d = col_q + 1'b1;
        if (col_q == CW'(SPR_W - 1)) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end
      end
      S_DRAIN: begin
        dcnt_d = dcnt_q + 3'd1;
        if (dcnt_q == 3'(ROM_LAT - 1)) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (s_q == '0) state_d = S_DONE;
        else begin
          s_d     = s_q - 1'b1;
          state_d = S_SCAN;
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase
    // start of a line: swap in whatever was rendered, aborting an unfinished render
    if (hcount_i == 10'd0 && state_q != S_IDLE) begin
      swap_now = 1'b1;
      abort    = (state_q != S_DONE);
      state_d  = S_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  assign disp_en  = (hcount_i < 10'(H_ACTIVE)) && (vcount_i < 10'(V_ACTIVE));
  assign haddr    = hcount_i[AW-1:0];
  assign disp_sel = swap_now ? ~sel_q : sel_q;
  assign wr_sel   = ~sel_q;
  assign wr_addr  = p_pos_q[ROM_LAT][AW-1:0];
  assign wr_en    = p_vld_q[ROM_LAT] && (rom_data_i != '0) &&
                    (p_pos_q[ROM_LAT] < 11'(H_ACTIVE)) && !swap_now;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s_q        <= '0;
      t_q        <= '0;
      id_q       <= '0;
      x_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      dcnt_q     <= '0;
      rom_addr_q <= '0;
      p_vld_q    <= '0;
      p_pos_q    <= '0;
      sel_q      <= 1'b0;
      overrun_q  <= 1'b0;
      pix_out_q  <= '0;
      clr_q      <= '0;
      clr_busy_q <= 1'b1;
    end else begin
      s_q    <= s_d;
      t_q    <= t_d;
      id_q   <= id_d;
      x_q    <= x_d;
      row_q  <= row_d;
      col_q  <= col_d;
      dcnt_q <= dcnt_d;
      if (issue) rom_addr_q <= {id_q, row_q, col_q};
      p_vld_q[0] <= issue;
      p_pos_q[0] <= {1'b0, x_q} + 11'(col_q);
      for (int i = 1; i <= ROM_LAT; i++) begin
        p_vld_q[i] <= p_vld_q[i-1];
        p_pos_q[i] <= p_pos_q[i-1];
      end
      if (swap_now) begin
        p_vld_q <= '0;
        sel_q   <= ~sel_q;
      end
      if (abort) overrun_q <= 1'b1;
      pix_out_q <= disp_en ? rd_data[disp_sel] : '0;
      if (clr_busy_q) begin
        clr_q <= clr_q + 1'b1;
        if (clr_q == AW'(H_ACTIVE - 1)) clr_busy_q <= 1'b0;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_buf
    logic [PIX_W-1:0] mem_q [H_ACTIVE];
    always_ff @(posedge clk_i) begin
      if (clr_busy_q)                           mem_q[clr_q]   <= '0;
      else if (disp_en && (disp_sel == 1'(b)))  mem_q[haddr]   <= '0;
      else if (wr_en && (wr_sel == 1'(b)))      mem_q[wr_addr] <= rom_data_i;
    end
    assign rd_data[b] = mem_q[haddr];
  end

  assign rom_addr_o = rom_addr_q;
  assign pix_out_o  = pix_out_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_sprite_line_engine.sv
// tb/tb_sprite_line_engine.sv - directed line-by-line checks of sprite_line_engine
// hcount sweeps 0..1023 per line, giving 384 blanking cycles for an 8-entry descriptor array.
module tb_sprite_line_engine;
  localparam int N_SPR = 8;
  localparam int PIX_W = 8;
  localparam int RAW   = 14;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [24*N_SPR-1:0] gl_array = '0;
  logic [9:0]         hcount = 10'd1023;
  logic [9:0]         vcount = 10'd500;
  logic [RAW-1:0]     rom_addr;
  logic [PIX_W-1:0]   rom_data = '0;
  logic [PIX_W-1:0]   pix_out;
  logic               overrun;

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] line_pix [640];
  int         exp_line [640];

  always #5 clk = ~clk;

  sprite_line_engine #(.N_SPR(N_SPR), .BLANK_CLKS(384)) dut (
    .clk_i(clk), .reset_i(reset), .gl_array_i(gl_array), .hcount_i(hcount),
    .vcount_i(vcount), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .pix_out_o(pix_out), .overrun_o(overrun)
  );

  // id1: col+1, id2: checkerboard 0/5, id3: solid 9
  function automatic logic [7:0] rom_f(input logic [RAW-1:0] a);
    logic [3:0] id;
    logic [4:0] row, col;
    id  = a[13:10];
    row = a[9:5];
    col = a[4:0];
    case (id)
      4'd1:    return 8'(col) + 8'd1;
      4'd2:    return (row[0] ^ col[0]) ? 8'd5 : 8'd0;
      4'd3:    return 8'd9;
      default: return 8'd0;
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_f(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_desc(input int idx, input int id, input int x, input int y);
    gl_array[idx*24 +: 24] = {4'(id), 10'(x), 10'(y)};
  endtask

  task automatic run_cycles(input int v, input int h_last);
    vcount = 10'(v);
    for (int h = 0; h <= h_last; h++) begin
      hcount = 10'(h);
      @(posedge clk);
      #1;
      if (h < 640) line_pix[h] = pix_out;
    end
  endtask

  task automatic run_line(input int v);
    run_cycles(v, 1023);
  endtask

  task automatic exp_clear();
    for (int h = 0; h < 640; h++) exp_line[h] = 0;
  endtask

  task automatic exp_ramp(input int x);
    for (int c = 0; c < 32; c++) if (x + c < 640) exp_line[x + c] = c + 1;
  endtask

  task automatic check_line(input string tag);
    int errs;
    errs = 0;
    for (int h = 0; h < 640; h++) if (line_pix[h] !== 8'(exp_line[h])) errs++;
    check(tag, errs, 0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pix", pix_out, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rom_addr", rom_addr, 0);
    reset = 1'b0;
    repeat (700) @(posedge clk);
    #1;

    exp_clear();
    run_line(0);
    check_line("empty_line0");
    run_line(479);
    check_line("empty_line479");

    set_desc(0, 1, 100, 50);
    run_line(49);
    run_line(50);
    exp_clear();
    exp_ramp(100);
    check_line("line50");
    check("line50_h99", line_pix[99], 0);
    check("line50_h100", line_pix[100], 1);
    check("line50_h131", line_pix[131], 32);
    check("line50_h132", line_pix[132], 0);
    run_line(81);
    check_line("line81_lastrow");
    run_line(82);
    exp_clear();
    check_line("line82_below");

    gl_array = '0;
    set_desc(3, 1, 200, 150);
    set_desc(2, 2, 200, 150);
    run_line(149);
    run_line(150);
    exp_clear();
    for (int c = 0; c < 32; c++) exp_line[200 + c] = (c % 2 == 1) ? 5 : c + 1;
    check_line("transp_line150");
    run_line(151);
    for (int c = 0; c < 32; c++) exp_line[200 + c] = (c % 2 == 0) ? 5 : c + 1;
    check_line("transp_line151");
    check("transp_h201", line_pix[201], 2);

    gl_array = '0;
    set_desc(0, 1, 300, 100);
    set_desc(5, 2, 300, 100);
    run_line(99);
    run_line(100);
    exp_clear();
    exp_ramp(300);
    check_line("overlap_line100");
    check("overlap_h301", line_pix[301], 2);

    gl_array = '0;
    set_desc(0, 1, 630, 200);
    set_desc(1, 3, 0, 1000);
    run_line(199);
    run_line(200);
    exp_clear();
    exp_ramp(630);
    check_line("clip_line200");
    check("clip_h639", line_pix[639], 10);
    run_line(201);
    check("clip_nowrap_h0", line_pix[0], 0);

    gl_array = '0;
    set_desc(0, 1, 50, 0);
    run_line(202);
    run_line(524);
    run_line(0);
    exp_clear();
    exp_ramp(50);
    check_line("wrap_line0");
    check("no_overrun_yet", overrun, 0);

    set_desc(7, 1, 400, 0);
    run_cycles(10, 649);
    run_line(11);
    check("overrun_set", overrun, 1);
    check("partial_h400", line_pix[400], 1);
    check("partial_h405", line_pix[405], 6);
    check("partial_h410", line_pix[410], 0);
    run_line(12);
    check("overrun_sticky", overrun, 1);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst2_overrun", overrun, 0);
    check("rst2_pix", pix_out, 0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
